tile_scheduler: RTL and testbench
=================================

Name: tile_scheduler

Overview:
- Top-level sequencer for the INT8 systolic array. It splits an M x K by K x N GEMM into PE-array-sized output tiles, with the M tile index outer and the N tile index inner.
- For each tile it runs three phases in order: streams K operand rows from the opnd1/opnd2 SRAMs, flushes the skewed array, then drains accumulator rows into the output SRAM.
- It drives the SRAM addresses and enables and the PE-array compute/flush flags. It reports completion to the top.

Parameters:
PE_ARRAY_NUM_ROWS, 32, rows in PE array
PE_ARRAY_NUM_ROWS_LOG2, 5, log2 of rows
PE_ARRAY_NUM_COLS, 32, cols in PE array
PE_ARRAY_NUM_COLS_LOG2, 5, log2 of cols
MAX_M_SIZE_LOG2, 9, width of M size
MAX_K_SIZE_LOG2, 9, width of K size
MAX_N_SIZE_LOG2, 9, width of N size
OPND1_SRAM_AWIDTH, 10, opnd1 SRAM address width
OPND2_SRAM_AWIDTH, 10, opnd2 SRAM address width
OUT_SRAM_AWIDTH, 10, output SRAM address width

Ports:
CLK  in  1  clock; one clock domain
RST  in  1  reset; synchronous, active-high
START  in  1  start request; sampled only in IDLE
STALL  in  1  freezes all state and counters
M_SIZE_in  in  MAX_M_SIZE_LOG2  rows of matrix A
K_SIZE_in  in  MAX_K_SIZE_LOG2  reduction depth
N_SIZE_in  in  MAX_N_SIZE_LOG2  columns of matrix B
OPND1_SRAM_ADDR_out  out  OPND1_SRAM_AWIDTH  A row address
OPND2_SRAM_ADDR_out  out  OPND2_SRAM_AWIDTH  B row address
OPND_RD_EN_out  out  1  operand read/FIFO push strobe
IS_COMPUTING_out  out  1  high in FEED
IS_FLUSHING_out  out  1  high in FLUSH
OUT_SRAM_ADDR_out  out  OUT_SRAM_AWIDTH  output row address
OUT_SRAM_WEn_out  out  1  output write enable, active-low
OUT_COL_VALID_out  out  PE_ARRAY_NUM_COLS  valid-column mask for the tile
BUSY_out  out  1  high when not IDLE
CFG_ERR_out  out  1  one-cycle pulse on zero-size START
IS_FINISHED_out  out  1  one-cycle pulse at end of run

Behaviour:
- Reset: state IDLE; all counters 0; all addresses 0; OUT_SRAM_WEn_out=1; OUT_COL_VALID_out=0; all other outputs 0. RST asserted in any state, including mid-run, returns to this state on the next edge.
- States: IDLE, LOAD, FEED, FLUSH, DRAIN, NEXT, DONE.
- IDLE: on START with any size equal to 0, pulse CFG_ERR_out and stay in IDLE. Otherwise go to LOAD.
- START outside IDLE is ignored.
- LOAD (1 cycle):
  - Latch M/K/N.
  - MT = ceil(M/ROWS), NT = ceil(N/COLS), computed with shift-add only.
  - m_t = n_t = 0.
  - Go to FEED.
- FEED (K cycles, k = 0..K-1):
  - OPND_RD_EN_out = 1.
  - OPND1 addr = m_t*K + k; OPND2 addr = n_t*K + k, each truncated mod 2^AWIDTH.
  - After k = K-1, go to FLUSH.
- FLUSH: exactly ROWS+COLS-2 cycles, then DRAIN.
- DRAIN (rv cycles, r = 0..rv-1):
  - rv = min(ROWS, M - m_t*ROWS).
  - OUT_SRAM_WEn_out = 0.
  - OUT addr = (m_t*NT + n_t)*ROWS + r, mod 2^OUT_SRAM_AWIDTH.
  - OUT_COL_VALID_out bit c = (n_t*COLS + c < N); it is valid throughout FEED, FLUSH and DRAIN of the tile.
- NEXT (1 cycle):
  - If n_t < NT-1: n_t++.
  - Else: n_t = 0 and m_t++.
  - If the tile just finished was the last one, go to DONE; else go to FEED.
- DONE (1 cycle): IS_FINISHED_out = 1, then IDLE.
- STALL=1 in any non-IDLE state:
  - State, counters and addresses hold.
  - OPND_RD_EN_out = 0 and OUT_SRAM_WEn_out = 1.
  - IS_COMPUTING_out and IS_FLUSHING_out hold their values.
  - A stall during DONE delays the IS_FINISHED_out pulse; the pulse is still exactly one unstalled cycle.
- STALL in IDLE has no effect; START is still sampled.
- Latency: first FEED cycle is 2 cycles after START is sampled.
- Per-tile length = K + (ROWS+COLS-2) + rv + 1.
- All outputs are registered.

Test Plan:
- Single tile, M=K=N=32, START at cycle 0:
  - LOAD at cycle 1.
  - FEED cycles 2-33; both addresses 0..31.
  - FLUSH cycles 34-95.
  - DRAIN cycles 96-127; OUT addr 0..31, WEn=0, col mask 0xFFFFFFFF.
  - NEXT at cycle 128; IS_FINISHED_out pulses at cycle 129; BUSY_out low at cycle 130.
- M=40, K=3, N=64:
  - Tile order (0,0), (0,1), (1,0), (1,1).
  - Tile (1,1): OPND1 addr 3,4,5; OPND2 addr 3,4,5; DRAIN exactly 8 rows at OUT addr 96..103.
- N=40, M=32, K=1: tile n_t=1 has OUT_COL_VALID_out = 0x000000FF; tile 0 has 0xFFFFFFFF.
- STALL high 5 cycles at the third FEED cycle (M=K=N=32):
  - OPND1 addr holds at 2 with RD_EN low.
  - Sequence resumes at 3; IS_FINISHED_out moves from cycle 129 to 134.
- START with K_SIZE_in=0: CFG_ERR_out pulses 1 cycle; BUSY_out stays 0; no IS_FINISHED_out.
- Second START during FEED is ignored.
- RST during DRAIN:
  - Next cycle all outputs are at reset values and WEn=1.
  - A fresh START with M=K=N=32 reproduces scenario 1 timing exactly.

Source files
------------

// File: rtl/tile_scheduler.sv
// Tile sequencer for the INT8 systolic array: walks M/N output tiles
// and drives operand feed, array flush and accumulator drain.
module tile_scheduler #(
  parameter int PE_ARRAY_NUM_ROWS      = 32,
  parameter int PE_ARRAY_NUM_ROWS_LOG2 = 5,
  parameter int PE_ARRAY_NUM_COLS      = 32,
  parameter int PE_ARRAY_NUM_COLS_LOG2 = 5,
  parameter int MAX_M_SIZE_LOG2        = 9,
  parameter int MAX_K_SIZE_LOG2        = 9,
  parameter int MAX_N_SIZE_LOG2        = 9,
  parameter int OPND1_SRAM_AWIDTH      = 10,
  parameter int OPND2_SRAM_AWIDTH      = 10,
  parameter int OUT_SRAM_AWIDTH        = 10
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         START,
  input  logic                         STALL,
  input  logic [MAX_M_SIZE_LOG2-1:0]   M_SIZE_in,
  input  logic [MAX_K_SIZE_LOG2-1:0]   K_SIZE_in,
  input  logic [MAX_N_SIZE_LOG2-1:0]   N_SIZE_in,
  output logic [OPND1_SRAM_AWIDTH-1:0] OPND1_SRAM_ADDR_out,
  output logic [OPND2_SRAM_AWIDTH-1:0] OPND2_SRAM_ADDR_out,
  output logic                         OPND_RD_EN_out,
  output logic                         IS_COMPUTING_out,
  output logic                         IS_FLUSHING_out,
  output logic [OUT_SRAM_AWIDTH-1:0]   OUT_SRAM_ADDR_out,
  output logic                         OUT_SRAM_WEn_out,
  output logic [PE_ARRAY_NUM_COLS-1:0] OUT_COL_VALID_out,
  output logic                         BUSY_out,
  output logic                         CFG_ERR_out,
  output logic                         IS_FINISHED_out
);

  localparam int MTW = MAX_M_SIZE_LOG2 - PE_ARRAY_NUM_ROWS_LOG2 + 1;
  localparam int NTW = MAX_N_SIZE_LOG2 - PE_ARRAY_NUM_COLS_LOG2 + 1;
  localparam int CW  = 16;
  localparam int A1W = OPND1_SRAM_AWIDTH;
  localparam int A2W = OPND2_SRAM_AWIDTH;
  localparam int OW  = OUT_SRAM_AWIDTH;
  localparam int ROWS = PE_ARRAY_NUM_ROWS;
  localparam int COLS = PE_ARRAY_NUM_COLS;

  typedef enum logic [2:0] {
    IDLE, LOAD, FEED, FLUSH, DRAIN, NEXT, DONE
  } state_t;

  state_t state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [MTW-1:0] mt_q, mt_n, m_t_q, m_t_n;
  logic [NTW-1:0] nt_q, nt_n, n_t_q, n_t_n;
  logic [MAX_K_SIZE_LOG2-1:0] k_q, k_n;
  logic [MAX_N_SIZE_LOG2-1:0] n_q, n_n;
  logic [MAX_M_SIZE_LOG2-1:0] m_rem_q, m_rem_n;
  logic [MAX_N_SIZE_LOG2-1:0] n_rem_q, n_rem_n;
  logic [A1W-1:0] base1_q, base1_n;
  logic [A2W-1:0] base2_q, base2_n;
  logic [OW-1:0] obase_q, obase_n;

  logic [A1W-1:0] a1_n;
  logic [A2W-1:0] a2_n;
  logic [OW-1:0] oa_n;
  logic rd_n, comp_n, flush_n, wen_n, busy_n, err_n, fin_n;
  logic [COLS-1:0] colv_n;

  logic [MAX_M_SIZE_LOG2:0] m_sum;
  logic [MAX_N_SIZE_LOG2:0] n_sum;
  logic [CW-1:0] rv;
  logic last_tile, size_zero, stalled;

  assign m_sum = {1'b0, M_SIZE_in} + (MAX_M_SIZE_LOG2+1)'(ROWS - 1);
  assign n_sum = {1'b0, N_SIZE_in} + (MAX_N_SIZE_LOG2+1)'(COLS - 1);
  assign rv = (m_rem_q >= MAX_M_SIZE_LOG2'(ROWS)) ?
              CW'(ROWS) : CW'(m_rem_q);
  assign last_tile = (m_t_q == mt_q - MTW'(1)) &&
                     (n_t_q == nt_q - NTW'(1));
  assign size_zero = (M_SIZE_in == '0) || (K_SIZE_in == '0) ||
                     (N_SIZE_in == '0);
  assign stalled = STALL && (state_q != IDLE);

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    mt_n    = mt_q;
    nt_n    = nt_q;
    m_t_n   = m_t_q;
    n_t_n   = n_t_q;
    k_n     = k_q;
    n_n     = n_q;
    m_rem_n = m_rem_q;
    n_rem_n = n_rem_q;
    base1_n = base1_q;
    base2_n = base2_q;
    obase_n = obase_q;
    err_n   = 1'b0;
    if (!stalled) begin
      unique case (state_q)
        IDLE: begin
          if (START && size_zero) err_n = 1'b1;
          else if (START) state_n = LOAD;
        end
        LOAD: begin
          k_n     = K_SIZE_in;
          n_n     = N_SIZE_in;
          m_rem_n = M_SIZE_in;
          n_rem_n = N_SIZE_in;
          mt_n    = MTW'(m_sum >> PE_ARRAY_NUM_ROWS_LOG2);
          nt_n    = NTW'(n_sum >> PE_ARRAY_NUM_COLS_LOG2);
          m_t_n   = '0;
          n_t_n   = '0;
          base1_n = '0;
          base2_n = '0;
          obase_n = '0;
          cnt_n   = '0;
          state_n = FEED;
        end
        FEED: begin
          if (cnt_q == CW'(k_q) - CW'(1)) begin
            cnt_n   = '0;
            state_n = FLUSH;
          end else cnt_n = cnt_q + CW'(1);
        end
        FLUSH: begin
          if (cnt_q == CW'(ROWS + COLS - 3)) begin
            cnt_n   = '0;
            state_n = DRAIN;
          end else cnt_n = cnt_q + CW'(1);
        end
        DRAIN: begin
          if (cnt_q + CW'(1) == rv) begin
            cnt_n   = '0;
            state_n = NEXT;
          end else cnt_n = cnt_q + CW'(1);
        end
        NEXT: begin
          obase_n = obase_q + OW'(ROWS);
          if (n_t_q != nt_q - NTW'(1)) begin
            n_t_n   = n_t_q + NTW'(1);
            n_rem_n = n_rem_q - MAX_N_SIZE_LOG2'(COLS);
            base2_n = base2_q + A2W'(k_q);
          end else begin
            n_t_n   = '0;
            n_rem_n = n_q;
            base2_n = '0;
            m_t_n   = m_t_q + MTW'(1);
            m_rem_n = m_rem_q - MAX_M_SIZE_LOG2'(ROWS);
            base1_n = base1_q + A1W'(k_q);
          end
          state_n = last_tile ? DONE : FEED;
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Output registers follow the next state so each phase shows up
  // in the same cycle the state register enters it.
  always_comb begin
    a1_n    = OPND1_SRAM_ADDR_out;
    a2_n    = OPND2_SRAM_ADDR_out;
    oa_n    = OUT_SRAM_ADDR_out;
    comp_n  = IS_COMPUTING_out;
    flush_n = IS_FLUSHING_out;
    colv_n  = OUT_COL_VALID_out;
    busy_n  = BUSY_out;
    rd_n    = 1'b0;
    wen_n   = 1'b1;
    fin_n   = 1'b0;
    if (!stalled) begin
      comp_n  = (state_n == FEED);
      flush_n = (state_n == FLUSH);
      busy_n  = (state_n != IDLE);
      fin_n   = (state_n == DONE);
      rd_n    = (state_n == FEED);
      wen_n   = (state_n != DRAIN);
      if (state_n == FEED) begin
        a1_n = base1_n + A1W'(cnt_n);
        a2_n = base2_n + A2W'(cnt_n);
      end
      if (state_n == DRAIN) oa_n = obase_n + OW'(cnt_n);
      colv_n = '0;
      if (state_n == FEED || state_n == FLUSH || state_n == DRAIN)
        for (int c = 0; c < COLS; c++)
          colv_n[c] = (32'(c) < 32'(n_rem_n));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mt_q    <= '0;
      nt_q    <= '0;
      m_t_q   <= '0;
      n_t_q   <= '0;
      k_q     <= '0;
      n_q     <= '0;
      m_rem_q <= '0;
      n_rem_q <= '0;
      base1_q <= '0;
      base2_q <= '0;
      obase_q <= '0;
      OPND1_SRAM_ADDR_out <= '0;
      OPND2_SRAM_ADDR_out <= '0;
      OPND_RD_EN_out      <= 1'b0;
      IS_COMPUTING_out    <= 1'b0;
      IS_FLUSHING_out     <= 1'b0;
      OUT_SRAM_ADDR_out   <= '0;
      OUT_SRAM_WEn_out    <= 1'b1;
      OUT_COL_VALID_out   <= '0;
      BUSY_out            <= 1'b0;
      CFG_ERR_out         <= 1'b0;
      IS_FINISHED_out     <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      mt_q    <= mt_n;
      nt_q    <= nt_n;
      m_t_q   <= m_t_n;
      n_t_q   <= n_t_n;
      k_q     <= k_n;
      n_q     <= n_n;
      m_rem_q <= m_rem_n;
      n_rem_q <= n_rem_n;
      base1_q <= base1_n;
      base2_q <= base2_n;
      obase_q <= obase_n;
      OPND1_SRAM_ADDR_out <= a1_n;
      OPND2_SRAM_ADDR_out <= a2_n;
      OPND_RD_EN_out      <= rd_n;
      IS_COMPUTING_out    <= comp_n;
      IS_FLUSHING_out     <= flush_n;
      OUT_SRAM_ADDR_out   <= oa_n;
      OUT_SRAM_WEn_out    <= wen_n;
      OUT_COL_VALID_out   <= colv_n;
      BUSY_out            <= busy_n;
      CFG_ERR_out         <= err_n;
      IS_FINISHED_out     <= fin_n;
    end
  end

endmodule

// File: tb/tb_tile_scheduler.sv
// Bench for tile_scheduler: table of GEMM runs with a read/write
// scoreboard, plus hand sequences for stall, restart, reset, bad size.
module tb_tile_scheduler;

  logic CLK = 0;
  logic RST = 1;
  logic START = 0;
  logic STALL = 0;
  logic [8:0] M_SIZE_in = 0, K_SIZE_in = 0, N_SIZE_in = 0;
  logic [9:0] OPND1_SRAM_ADDR_out, OPND2_SRAM_ADDR_out;
  logic OPND_RD_EN_out, IS_COMPUTING_out, IS_FLUSHING_out;
  logic [9:0] OUT_SRAM_ADDR_out;
  logic OUT_SRAM_WEn_out;
  logic [31:0] OUT_COL_VALID_out;
  logic BUSY_out, CFG_ERR_out, IS_FINISHED_out;

  tile_scheduler dut (
    .CLK(CLK), .RST(RST), .START(START), .STALL(STALL),
    .M_SIZE_in(M_SIZE_in), .K_SIZE_in(K_SIZE_in),
    .N_SIZE_in(N_SIZE_in),
    .OPND1_SRAM_ADDR_out(OPND1_SRAM_ADDR_out),
    .OPND2_SRAM_ADDR_out(OPND2_SRAM_ADDR_out),
    .OPND_RD_EN_out(OPND_RD_EN_out),
    .IS_COMPUTING_out(IS_COMPUTING_out),
    .IS_FLUSHING_out(IS_FLUSHING_out),
    .OUT_SRAM_ADDR_out(OUT_SRAM_ADDR_out),
    .OUT_SRAM_WEn_out(OUT_SRAM_WEn_out),
    .OUT_COL_VALID_out(OUT_COL_VALID_out),
    .BUSY_out(BUSY_out), .CFG_ERR_out(CFG_ERR_out),
    .IS_FINISHED_out(IS_FINISHED_out)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [9:0] a1;
    logic [9:0] a2;
    logic [31:0] mask;
  } rd_t;
  typedef struct {
    logic [9:0] a;
    logic [31:0] mask;
  } wr_t;
  rd_t rd_q[$];
  wr_t wr_q[$];

  typedef struct {
    int m; int k; int n;
    int fin; int stall_at; int restart_at; int rst_at;
  } vec_t;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    if (OPND_RD_EN_out) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        rd_t e;
        e = rd_q.pop_front();
        chk("opnd1_addr", OPND1_SRAM_ADDR_out, e.a1);
        chk("opnd2_addr", OPND2_SRAM_ADDR_out, e.a2);
        chk("feed_mask", OUT_COL_VALID_out, e.mask);
      end
    end
    if (!OUT_SRAM_WEn_out) begin
      if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        wr_t w;
        w = wr_q.pop_front();
        chk("out_addr", OUT_SRAM_ADDR_out, w.a);
        chk("drain_mask", OUT_COL_VALID_out, w.mask);
      end
    end
  end

  task automatic push_expect(int m, int k, int n);
    int mt, nt, rv;
    logic [31:0] mask;
    mt = (m + 31) / 32;
    nt = (n + 31) / 32;
    for (int i = 0; i < mt; i++)
      for (int j = 0; j < nt; j++) begin
        for (int c = 0; c < 32; c++) mask[c] = (j * 32 + c < n);
        for (int kk = 0; kk < k; kk++) begin
          rd_t e;
          e.a1 = 10'((i * k + kk) % 1024);
          e.a2 = 10'((j * k + kk) % 1024);
          e.mask = mask;
          rd_q.push_back(e);
        end
        rv = (m - i * 32 < 32) ? m - i * 32 : 32;
        for (int r = 0; r < rv; r++) begin
          wr_t w;
          w.a = 10'(((i * nt + j) * 32 + r) % 1024);
          w.mask = mask;
          wr_q.push_back(w);
        end
      end
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_busy"}, BUSY_out, 0);
    chk({tag, "_wen"}, OUT_SRAM_WEn_out, 1);
    chk({tag, "_colv"}, OUT_COL_VALID_out, 0);
    chk({tag, "_rd"}, OPND_RD_EN_out, 0);
    chk({tag, "_a1"}, OPND1_SRAM_ADDR_out, 0);
    chk({tag, "_oa"}, OUT_SRAM_ADDR_out, 0);
    chk({tag, "_flush"}, IS_FLUSHING_out, 0);
    chk({tag, "_fin"}, IS_FINISHED_out, 0);
  endtask

  task automatic run(vec_t v);
    int c0, d, bound;
    bit done;
    push_expect(v.m, v.k, v.n);
    @(negedge CLK);
    M_SIZE_in = 9'(v.m);
    K_SIZE_in = 9'(v.k);
    N_SIZE_in = 9'(v.n);
    START = 1;
    c0 = cyc;
    done = 0;
    bound = (v.rst_at != 0) ? v.rst_at + 2 : v.fin + 20;
    for (int it = 0; it < bound && !done; it++) begin
      @(negedge CLK);
      d = cyc - c0;
      START = (v.restart_at != 0 && d == v.restart_at);
      if (v.stall_at != 0 && d == v.stall_at) STALL = 1;
      if (v.stall_at != 0 && d == v.stall_at + 5) STALL = 0;
      if (d == 1) begin
        chk("load_busy", BUSY_out, 1);
        chk("load_comp", IS_COMPUTING_out, 0);
      end
      if (d == 2) chk("feed_comp", IS_COMPUTING_out, 1);
      if (v.stall_at != 0 && d == v.stall_at + 3) begin
        chk("stall_rd", OPND_RD_EN_out, 0);
        chk("stall_a1", OPND1_SRAM_ADDR_out, 2);
        chk("stall_comp", IS_COMPUTING_out, 1);
      end
      if (v.stall_at != 0 && d == v.stall_at + 6) begin
        chk("resume_a1", OPND1_SRAM_ADDR_out, 3);
        chk("resume_rd", OPND_RD_EN_out, 1);
      end
      if (v.rst_at != 0 && d == v.rst_at) RST = 1;
      if (v.rst_at != 0 && d == v.rst_at + 1) begin
        check_reset_outputs("midrun_rst");
        RST = 0;
        rd_q.delete();
        wr_q.delete();
        done = 1;
      end
      if (v.rst_at == 0 && IS_FINISHED_out) begin
        chk("finish_cycle", d, v.fin);
        @(negedge CLK);
        chk("fin_pulse_width", IS_FINISHED_out, 0);
        chk("idle_busy", BUSY_out, 0);
        done = 1;
      end
    end
    START = 0;
    STALL = 0;
    if (!done) chk("run_timeout", 0, 1);
    chk("rd_left", rd_q.size(), 0);
    chk("wr_left", wr_q.size(), 0);
    rd_q.delete();
    wr_q.delete();
  endtask

  vec_t vecs[8];
  int fin_seen;

  initial begin
    vecs[0] = '{32, 32, 32, 129, 0, 0, 0};
    vecs[1] = '{40, 3, 64, 346, 0, 0, 0};
    vecs[2] = '{32, 1, 40, 194, 0, 0, 0};
    vecs[3] = '{1, 1, 1, 67, 0, 0, 0};
    vecs[4] = '{33, 2, 1, 165, 0, 0, 0};
    vecs[5] = '{32, 32, 32, 134, 4, 0, 0};
    vecs[6] = '{32, 32, 32, 129, 0, 5, 0};
    vecs[7] = '{32, 32, 32, 0, 0, 0, 100};

    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    chk("reset_err", CFG_ERR_out, 0);
    RST = 0;
    @(negedge CLK);

    for (int i = 0; i < 8; i++) run(vecs[i]);
    run(vecs[0]);

    @(negedge CLK);
    M_SIZE_in = 32;
    K_SIZE_in = 0;
    N_SIZE_in = 32;
    START = 1;
    @(negedge CLK);
    START = 0;
    chk("cfg_err_pulse", CFG_ERR_out, 1);
    chk("cfg_err_busy", BUSY_out, 0);
    @(negedge CLK);
    chk("cfg_err_width", CFG_ERR_out, 0);
    fin_seen = 0;
    for (int i = 0; i < 140; i++) begin
      @(negedge CLK);
      if (IS_FINISHED_out || BUSY_out) fin_seen++;
    end
    chk("cfg_err_no_run", fin_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
